wb_queue: RTL and testbench

//  Write-back queue feeding the dual write ports (slot 0 / slot 1) of the 32x32 register file.

---
 rtl/wb_queue_if.sv | 46 ++++
 rtl/wb_queue.sv | 102 ++++++++++
 tb/tb_wb_queue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
// Bundle between the execute pipes / register file and the write-back queue.
// The slave modport is the queue; the master modport is whoever drives results and the drain hold.
interface wb_queue_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in0_valid;
  logic [AW-1:0] in0_addr;
  logic [DW-1:0] in0_data;
  logic          in1_valid;
  logic [AW-1:0] in1_addr;
  logic [DW-1:0] in1_data;
  logic          in_ready;
  logic          drain_hold;
  logic          we;
  logic [AW-1:0] writeaddr;
  logic [DW-1:0] writedata;
  logic          we2;
  logic [AW-1:0] writeaddr2;
  logic [DW-1:0] writedata2;
  logic [CW-1:0] count;
  logic [31:0]   pending_mask;

  modport slave (
    input  in0_valid, in0_addr, in0_data,
    input  in1_valid, in1_addr, in1_data,
    input  drain_hold,
    output in_ready,
    output we, writeaddr, writedata,
    output we2, writeaddr2, writedata2,
    output count, pending_mask
  );

  modport master (
    output in0_valid, in0_addr, in0_data,
    output in1_valid, in1_addr, in1_data,
    output drain_hold,
    input  in_ready,
    input  we, writeaddr, writedata,
    input  we2, writeaddr2, writedata2,
    input  count, pending_mask
  );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back queue: takes up to two results per cycle, drains up to two per cycle to the
// dual-port regfile, never two same-register writes in one cycle. Optional WBQ_PENDING_EN: pending_mask.
module wb_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic       clk,
  input logic       rst_n,
  wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  logic [PW-1:0] rd_ptr1;
  logic [PW-1:0] wr_slot1;
  logic          ready;
  logic          drain0;
  logic          drain1;
  logic          acc0;
  logic          acc1;
  logic [CW-1:0] n_drain;
  logic [CW-1:0] n_enq;

  assign rd_ptr1 = rd_ptr + PW'(1);
  assign ready   = (CW'(DEPTH) - count_q) >= CW'(2);

  // Second slot only drains when it cannot collide with slot 0 on the same register.
  assign drain0 = !bus.drain_hold && (count_q != '0);
  assign drain1 = !bus.drain_hold && (count_q >= CW'(2)) &&
                  (addr_mem[rd_ptr1] != addr_mem[rd_ptr]);

  // x0 results are accepted but dropped, so they never take a slot.
  assign acc0 = ready && bus.in0_valid && (bus.in0_addr != '0);
  assign acc1 = ready && bus.in1_valid && (bus.in1_addr != '0);

  assign n_drain  = CW'(drain0) + CW'(drain1);
  assign n_enq    = CW'(acc0) + CW'(acc1);
  assign wr_slot1 = acc0 ? (wr_ptr + PW'(1)) : wr_ptr;

  assign bus.in_ready   = ready;
  assign bus.count      = count_q;
  assign bus.we         = drain0;
  assign bus.writeaddr  = drain0 ? addr_mem[rd_ptr]  : '0;
  assign bus.writedata  = drain0 ? data_mem[rd_ptr]  : '0;
  assign bus.we2        = drain1;
  assign bus.writeaddr2 = drain1 ? addr_mem[rd_ptr1] : '0;
  assign bus.writedata2 = drain1 ? data_mem[rd_ptr1] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(n_drain);
      wr_ptr  <= wr_ptr + PW'(n_enq);
      count_q <= count_q + n_enq - n_drain;
    end
  end

  // Storage needs no reset: occupancy is defined purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (acc0) begin
      addr_mem[wr_ptr] <= bus.in0_addr;
      data_mem[wr_ptr] <= bus.in0_data;
    end
    if (acc1) begin
      addr_mem[wr_slot1] <= bus.in1_addr;
      data_mem[wr_slot1] <= bus.in1_data;
    end
  end

`ifdef WBQ_PENDING_EN
  logic [31:0]   pend;
  logic [PW-1:0] offset;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    pend   = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if (CW'(offset) < count_q) begin
        pend[addr_mem[i]] = 1'b1;
      end
    end
    pend[0] = 1'b0;
  end

  assign bus.pending_mask = pend;
`else
  assign bus.pending_mask = 32'h0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic against a queue model.
module tb_wb_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [AW-1:0] mq_a [$];
  logic [DW-1:0] mq_d [$];
  logic [DW-1:0] rf [32];

  wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] pm;
    pm = '0;
`ifdef WBQ_PENDING_EN
    foreach (mq_a[i]) pm[mq_a[i]] = 1'b1;
`endif
    return pm;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic hold);
    int   sz;
    logic e_rdy, e_we0, e_we1;
    bus.in0_valid  = v0;
    bus.in0_addr   = a0;
    bus.in0_data   = d0;
    bus.in1_valid  = v1;
    bus.in1_addr   = a1;
    bus.in1_data   = d1;
    bus.drain_hold = hold;
    @(negedge clk);
    sz    = mq_a.size();
    e_rdy = (DEPTH - sz) >= 2;
    e_we0 = !hold && sz >= 1;
    e_we1 = !hold && sz >= 2 && (mq_a[1] != mq_a[0]);
    chk("in_ready", bus.in_ready, e_rdy);
    chk("count", bus.count, sz);
    chk("we", bus.we, e_we0);
    chk("writeaddr", bus.writeaddr, e_we0 ? mq_a[0] : '0);
    chk("writedata", bus.writedata, e_we0 ? mq_d[0] : '0);
    chk("we2", bus.we2, e_we1);
    chk("writeaddr2", bus.writeaddr2, e_we1 ? mq_a[1] : '0);
    chk("writedata2", bus.writedata2, e_we1 ? mq_d[1] : '0);
    chk("pending_mask", bus.pending_mask, model_pending());
    if (bus.we)  rf[bus.writeaddr]  = bus.writedata;
    if (bus.we2) rf[bus.writeaddr2] = bus.writedata2;
    @(posedge clk);
    if (e_we0) begin void'(mq_a.pop_front()); void'(mq_d.pop_front()); end
    if (e_we1) begin void'(mq_a.pop_front()); void'(mq_d.pop_front()); end
    if (e_rdy) begin
      if (v0 && a0 != '0) begin mq_a.push_back(a0); mq_d.push_back(d0); end
      if (v1 && a1 != '0) begin mq_a.push_back(a1); mq_d.push_back(d1); end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    foreach (rf[i]) rf[i] = '0;
    rst_n          = 1'b0;
    bus.in0_valid  = 1'b0;
    bus.in0_addr   = '0;
    bus.in0_data   = '0;
    bus.in1_valid  = 1'b0;
    bus.in1_addr   = '0;
    bus.in1_data   = '0;
    bus.drain_hold = 1'b0;

    // Reset state
    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_we2", bus.we2, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_writeaddr", bus.writeaddr, 0);
    chk("rst_writedata2", bus.writedata2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle();

    // Pair of distinct registers drains together
    cycle(1'b1, 5'd5, 32'hAAAA0001, 1'b1, 5'd6, 32'hBBBB0002, 1'b0);
    idle();
    idle();
    chk("pair_x5", rf[5], 32'hAAAA0001);
    chk("pair_x6", rf[6], 32'hBBBB0002);

    // Same-register pair drains in program order over two cycles
    cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b0);
    idle();
    idle();
    idle();
    chk("same_x7", rf[7], 32'd2);

    // x0 result discarded
    cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd9, 32'd3, 1'b0);
    idle();
    idle();
    chk("x0_x9", rf[9], 32'd3);
    chk("x0_x0", rf[0], 32'd0);

    // Fill under hold until full, then drain; three rounds wrap the pointers
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 6; j++) begin
        cycle(1'b1, 5'(2 * j + 1), $urandom, 1'b1, 5'(2 * j + 2), $urandom, 1'b1);
      end
      chk("full_count", bus.count, DEPTH);
      for (int j = 0; j < 6; j++) idle();
      chk("drained_count", bus.count, 0);
    end

    // Random traffic with collisions, x0 results and random hold
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom), 5'($urandom_range(0, 9)), $urandom,
            1'($urandom), 5'($urandom_range(0, 9)), $urandom,
            ($urandom_range(0, 3) == 0));
    end
    for (int k = 0; k < 6; k++) idle();

    // Asynchronous reset with five queued entries
    cycle(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, 1'b1);
    cycle(1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'h15, 1'b1);
    chk("pre_rst_count", bus.count, 5);
    bus.in1_valid  = 1'b0;
    bus.drain_hold = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_we", bus.we, 0);
    chk("mid_rst_we2", bus.we2, 0);
    chk("mid_rst_pending", bus.pending_mask, 0);
    chk("mid_rst_writeaddr", bus.writeaddr, 0);
    mq_a.delete();
    mq_d.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
